// File: rtl/sram_arbiter.sv
// Two-requester (IFU read-only, LSU read/write) arbiter and sequencer for a single SRAM port.
// One access in flight at a time; a watchdog turns a missing sram_valid into an error response.
module sram_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ready,
  output logic        ifu_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req,
  input  logic        lsu_wen,
  input  logic [7:0]  lsu_wmask,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_ready,
  output logic        lsu_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        sram_ren,
  output logic        sram_wen,
  output logic [7:0]  sram_wmask,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_data,
  input  logic        sram_valid,
  output logic        timeout_seen
);

  // state  | meaning
  // IDLE   | no access in flight, grants allowed
  // ISSUE  | one-cycle ren/wen strobe
  // WAIT   | waiting for sram_valid, watchdog counting
  // RESP   | one-cycle response pulse to the owner
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        last_lsu_q, last_lsu_d;
  logic        owner_lsu_q, owner_lsu_d;
  logic        is_write_q, is_write_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [7:0]  wmask_q, wmask_d;
  logic        ifu_valid_q, ifu_valid_d;
  logic [31:0] ifu_rdata_q, ifu_rdata_d;
  logic        ifu_err_q, ifu_err_d;
  logic        lsu_valid_q, lsu_valid_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        lsu_err_q, lsu_err_d;
  logic        tseen_q, tseen_d;

  logic        idle_ok, lsu_wins, grant_lsu, grant_ifu;
  logic        resp_go, resp_err;
  logic [31:0] resp_data;

  // Ready is masked during reset so nothing is accepted while rst is high.
  always_comb begin
    idle_ok   = (state_q == S_IDLE) && !rst;
    lsu_wins  = lsu_req && (!ifu_req || !last_lsu_q);
    grant_lsu = idle_ok && lsu_wins;
    grant_ifu = idle_ok && ifu_req && !lsu_wins;
  end

  always_comb begin
    state_d     = state_q;
    last_lsu_d  = last_lsu_q;
    owner_lsu_d = owner_lsu_q;
    is_write_d  = is_write_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tseen_d     = tseen_q;
    ren_d       = 1'b0;
    wen_d       = 1'b0;
    wmask_d     = '0;
    ifu_valid_d = 1'b0;
    ifu_rdata_d = '0;
    ifu_err_d   = 1'b0;
    lsu_valid_d = 1'b0;
    lsu_rdata_d = '0;
    lsu_err_d   = 1'b0;
    resp_go     = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_ifu || grant_lsu) begin
          owner_lsu_d = grant_lsu;
          last_lsu_d  = grant_lsu;
          is_write_d  = grant_lsu && lsu_wen;
          addr_d      = grant_lsu ? lsu_addr : ifu_addr;
          wdata_d     = grant_lsu ? lsu_wdata : '0;
          ren_d       = !(grant_lsu && lsu_wen);
          wen_d       = grant_lsu && lsu_wen;
          wmask_d     = (grant_lsu && lsu_wen) ? lsu_wmask : '0;
          cnt_d       = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (sram_valid) begin
          resp_go   = 1'b1;
          resp_data = sram_data;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completion in the expiry cycle still counts as success.
        if (sram_valid) begin
          resp_go   = 1'b1;
          resp_data = sram_data;
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
          tseen_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (resp_go) begin
      state_d = S_RESP;
      if (owner_lsu_q) begin
        lsu_valid_d = 1'b1;
        lsu_rdata_d = is_write_q ? '0 : resp_data;
        lsu_err_d   = resp_err;
      end else begin
        ifu_valid_d = 1'b1;
        ifu_rdata_d = resp_data;
        ifu_err_d   = resp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_lsu_q  <= 1'b0;
      owner_lsu_q <= 1'b0;
      is_write_q  <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      wmask_q     <= '0;
      ifu_valid_q <= 1'b0;
      ifu_rdata_q <= '0;
      ifu_err_q   <= 1'b0;
      lsu_valid_q <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_err_q   <= 1'b0;
      tseen_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_lsu_q  <= last_lsu_d;
      owner_lsu_q <= owner_lsu_d;
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      wmask_q     <= wmask_d;
      ifu_valid_q <= ifu_valid_d;
      ifu_rdata_q <= ifu_rdata_d;
      ifu_err_q   <= ifu_err_d;
      lsu_valid_q <= lsu_valid_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_err_q   <= lsu_err_d;
      tseen_q     <= tseen_d;
    end
  end

  assign ifu_ready    = grant_ifu;
  assign lsu_ready    = grant_lsu;
  assign ifu_valid    = ifu_valid_q;
  assign ifu_rdata    = ifu_rdata_q;
  assign ifu_err      = ifu_err_q;
  assign lsu_valid    = lsu_valid_q;
  assign lsu_rdata    = lsu_rdata_q;
  assign lsu_err      = lsu_err_q;
  assign sram_ren     = ren_q;
  assign sram_wen     = wen_q;
  assign sram_wmask   = wmask_q;
  assign sram_addr    = addr_q;
  assign sram_wdata   = wdata_q;
  assign timeout_seen = tseen_q;

endmodule
